wishbone_arbiter2: RTL and testbench

//   Two-master, one-slave Wishbone classic arbiter for the 24-bit-address / 16-bit-data register bus.

---
 rtl/wishbone_arbiter2.sv | 163 ++++++++++++++++
 tb/tb_wishbone_arbiter2.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter2.sv
// Two-master / one-slave Wishbone classic arbiter for the 24-bit address,
// 16-bit data register bus. A round-robin grant is held for a whole cyc.
// A watchdog terminates slave cycles that never ack by returning err to the
// owning master for one cycle and releasing the bus.
module wishbone_arbiter2 #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] m0AdrI,
    input  logic [DATA_WIDTH-1:0] m0DatI,
    output logic [DATA_WIDTH-1:0] m0DatO,
    input  logic                  m0CycI,
    input  logic                  m0StbI,
    input  logic                  m0WeI,
    output logic                  m0AckO,
    output logic                  m0ErrO,

    input  logic [ADDR_WIDTH-1:0] m1AdrI,
    input  logic [DATA_WIDTH-1:0] m1DatI,
    output logic [DATA_WIDTH-1:0] m1DatO,
    input  logic                  m1CycI,
    input  logic                  m1StbI,
    input  logic                  m1WeI,
    output logic                  m1AckO,
    output logic                  m1ErrO,

    output logic [ADDR_WIDTH-1:0] sAdrO,
    output logic [DATA_WIDTH-1:0] sDatO,
    input  logic [DATA_WIDTH-1:0] sDatI,
    output logic                  sCycO,
    output logic                  sStbO,
    output logic                  sWeO,
    input  logic                  sAckI,

    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Watchdog fires on the strobe cycle where the timer has counted
    // TIMEOUT_CYCLES-1 earlier unacknowledged strobe cycles.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_owner;       // 0 = m0 owned last, 1 = m1 owned last
    logic        last_owner_next;
    logic [15:0] timer;

    logic        owner_cyc;
    logic        owner_stb;
    logic        stb_raw;
    logic        err_pulse;

    // Grant is decoded straight from the state so an async reset drops it at once.
    assign grant = {state == OWN1, state == OWN0};

    // Route the owning master's request signals onto the slave port.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        sAdrO     = '0;
        sDatO     = '0;
        sWeO      = 1'b0;
        case (state)
            OWN0: begin
                owner_cyc = m0CycI;
                owner_stb = m0StbI;
                sAdrO     = m0AdrI;
                sDatO     = m0DatI;
                sWeO      = m0WeI;
            end
            OWN1: begin
                owner_cyc = m1CycI;
                owner_stb = m1StbI;
                sAdrO     = m1AdrI;
                sDatO     = m1DatI;
                sWeO      = m1WeI;
            end
            default: ;
        endcase
    end

    // A master dropping cyc removes the slave strobe in the same cycle.
    assign stb_raw   = owner_cyc & owner_stb;
    // An ack arriving on the timeout cycle wins over the watchdog.
    assign err_pulse = stb_raw & ~sAckI & (timer == TIMER_LAST);

    assign sCycO  = owner_cyc;
    assign sStbO  = stb_raw & ~err_pulse;

    assign m0AckO = sAckI & sStbO & grant[0];
    assign m1AckO = sAckI & sStbO & grant[1];
    assign m0ErrO = err_pulse & grant[0];
    assign m1ErrO = err_pulse & grant[1];

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0DatO = sDatI;
    assign m1DatO = sDatI;

    // Next-state logic: round-robin on ties, release on cyc drop or timeout.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (m0CycI && m1CycI) begin
                    state_next = last_owner ? OWN0 : OWN1;
                end else if (m0CycI) begin
                    state_next = OWN0;
                end else if (m1CycI) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (err_pulse || !m0CycI) begin
                    state_next      = IDLE;
                    last_owner_next = 1'b0;
                end
            end
            OWN1: begin
                if (err_pulse || !m1CycI) begin
                    state_next      = IDLE;
                    last_owner_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and round-robin history registers; m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
        end
    end

    // Watchdog counts consecutive unacknowledged strobe cycles of the owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (state == IDLE || sAckI || !sStbO) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural
// reference model of the arbitration and watchdog rules.
module tb_wishbone_arbiter2;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0AdrI, m1AdrI, sAdrO;
    logic [DW-1:0] m0DatI, m1DatI, m0DatO, m1DatO, sDatO, sDatI;
    logic          m0CycI, m0StbI, m0WeI, m0AckO, m0ErrO;
    logic          m1CycI, m1StbI, m1WeI, m1AckO, m1ErrO;
    logic          sCycO, sStbO, sWeO, sAckI;
    logic [1:0]    grant;

    wishbone_arbiter2 #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),    .rst   (rst),
        .m0AdrI(m0AdrI), .m0DatI(m0DatI), .m0DatO(m0DatO), .m0CycI(m0CycI),
        .m0StbI(m0StbI), .m0WeI (m0WeI),  .m0AckO(m0AckO), .m0ErrO(m0ErrO),
        .m1AdrI(m1AdrI), .m1DatI(m1DatI), .m1DatO(m1DatO), .m1CycI(m1CycI),
        .m1StbI(m1StbI), .m1WeI (m1WeI),  .m1AckO(m1AckO), .m1ErrO(m1ErrO),
        .sAdrO (sAdrO),  .sDatO (sDatO),  .sDatI (sDatI),  .sCycO (sCycO),
        .sStbO (sStbO),  .sWeO  (sWeO),   .sAckI (sAckI),  .grant (grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who owned it
    // last, and how many unacknowledged strobe cycles the owner has seen.
    int m_owner = 0;
    int m_last  = 2;
    int m_cnt   = 0;

    // Expectations for the current cycle, kept for the model update.
    logic          e_ocyc, e_err, e_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle();
        logic          ostb, owe, raw, eack;
        logic [AW-1:0] oadr;
        logic [DW-1:0] odat;
        logic [1:0]    egrant;
        #1;
        if (!rst) begin
            m_owner = 0;
            m_last  = 2;
            m_cnt   = 0;
        end
        e_ocyc = 1'b0; ostb = 1'b0; owe = 1'b0; oadr = '0; odat = '0;
        egrant = 2'b00;
        if (m_owner == 1) begin
            e_ocyc = m0CycI; ostb = m0StbI; owe = m0WeI; oadr = m0AdrI; odat = m0DatI;
            egrant = 2'b01;
        end else if (m_owner == 2) begin
            e_ocyc = m1CycI; ostb = m1StbI; owe = m1WeI; oadr = m1AdrI; odat = m1DatI;
            egrant = 2'b10;
        end
        raw   = e_ocyc && ostb;
        e_err = raw && !sAckI && (m_cnt == TO - 1);
        e_stb = raw && !e_err;
        eack  = sAckI && e_stb;
        chk("grant",  32'(grant),  32'(egrant));
        chk("s_cyc",  32'(sCycO),  32'(e_ocyc));
        chk("s_stb",  32'(sStbO),  32'(e_stb));
        chk("s_we",   32'(sWeO),   32'(owe));
        chk("s_adr",  32'(sAdrO),  32'(oadr));
        chk("s_dat",  32'(sDatO),  32'(odat));
        chk("m0_ack", 32'(m0AckO), 32'(eack && m_owner == 1));
        chk("m1_ack", 32'(m1AckO), 32'(eack && m_owner == 2));
        chk("m0_err", 32'(m0ErrO), 32'(e_err && m_owner == 1));
        chk("m1_err", 32'(m1ErrO), 32'(e_err && m_owner == 2));
        chk("m0_dat", 32'(m0DatO), 32'(sDatI));
        chk("m1_dat", 32'(m1DatO), 32'(sDatI));
    endtask

    // Apply the arbitration rules across one clock edge; inputs stay unchanged.
    task automatic advance();
        int nxt_owner, nxt_last, nxt_cnt;
        nxt_owner = m_owner;
        nxt_last  = m_last;
        nxt_cnt   = 0;
        if (rst) begin
            if (m_owner == 0) begin
                if (m0CycI && (!m1CycI || m_last == 2)) nxt_owner = 1;
                else if (m1CycI)                        nxt_owner = 2;
            end else if (e_err || !e_ocyc) begin
                nxt_owner = 0;
                nxt_last  = m_owner;
            end
            nxt_cnt = (m_owner == 0 || sAckI || !e_stb) ? 0 : m_cnt + 1;
        end
        @(posedge clk);
        if (rst) begin
            m_owner = nxt_owner;
            m_last  = nxt_last;
            m_cnt   = nxt_cnt;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic set_m0(input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0CycI = cyc; m0StbI = stb; m0WeI = we; m0AdrI = adr; m0DatI = dat;
    endtask

    task automatic set_m1(input logic cyc, input logic stb, input logic we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m1CycI = cyc; m1StbI = stb; m1WeI = we; m1AdrI = adr; m1DatI = dat;
    endtask

    initial begin
        logic [1:0] gseq[$];
        logic [1:0] gexp[5];
        logic [1:0] gprev;
        int rise, errc;
        logic [0:11] t2_m0, t2_m1;

        rst = 1'b0;
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        sAckI = 1'b0;
        sDatI = '0;

        // Reset: everything quiet even with a master requesting.
        m0CycI = 1'b1; m0StbI = 1'b1;
        tick();
        settle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc",  32'(sCycO), 32'h0);
        advance();
        rst = 1'b1;
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // 1: single m0 read, slave acks as soon as strobe is seen.
        set_m0(1'b1, 1'b1, 1'b0, 24'h000010, 16'h0);
        sDatI = 16'h1234;
        sAckI = 1'b1;
        settle();
        chk("t1_idle_grant", 32'(grant),  32'h0);
        chk("t1_idle_ack",   32'(m0AckO), 32'h0);
        advance();
        settle();
        chk("t1_grant",  32'(grant),  32'h1);
        chk("t1_scyc",   32'(sCycO),  32'h1);
        chk("t1_ack",    32'(m0AckO), 32'h1);
        chk("t1_data",   32'(m0DatO), 32'h1234);
        chk("t1_m1_ack", 32'(m1AckO), 32'h0);
        advance();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        sAckI = 1'b0;
        tick();
        tick();

        // 2: both masters request from reset; grant sequence 01,00,10,00,01.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        t2_m0 = 12'b1111_0111_1111;
        t2_m1 = 12'b1111_1111_1011;
        gseq.delete();
        for (int i = 0; i < 12; i++) begin
            m0CycI = t2_m0[i];
            m1CycI = t2_m1[i];
            settle();
            if (i > 0 && (gseq.size() == 0 || gprev !== grant)) gseq.push_back(grant);
            gprev = grant;
            advance();
        end
        gexp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        chk("t2_seq_len", 32'(gseq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gseq.size(); i++) chk("t2_seq", 32'(gseq[i]), 32'(gexp[i]));
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        // 3: m1 write while m0 idle.
        set_m1(1'b1, 1'b1, 1'b1, 24'hA00003, 16'hBEEF);
        sAckI = 1'b1;
        tick();
        settle();
        chk("t3_adr", 32'(sAdrO),  32'hA00003);
        chk("t3_dat", 32'(sDatO),  32'hBEEF);
        chk("t3_we",  32'(sWeO),   32'h1);
        chk("t3_ack", 32'(m1AckO), 32'h1);
        advance();
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        sAckI = 1'b0;
        tick();
        tick();

        // 4: slave never acks m0; m1 waits with a pending request.
        set_m0(1'b1, 1'b1, 1'b0, 24'h000100, 16'h0);
        set_m1(1'b1, 1'b1, 1'b0, 24'h000200, 16'h0);
        rise = -1;
        errc = -1;
        for (int i = 0; i < 20 && errc < 0; i++) begin
            settle();
            if (rise < 0 && sStbO) rise = i;
            if (m0ErrO) begin
                errc = i;
                chk("t4_stb_low_on_err", 32'(sStbO), 32'h0);
            end
            advance();
        end
        chk("t4_err_seen", 32'(errc >= 0), 32'h1);
        // The strobe stays up while the timer runs 0..TO-2; err lands when it reads TO-1.
        chk("t4_err_distance", 32'(errc - rise), 32'(TO - 1));
        settle();
        chk("t4_grant_idle", 32'(grant), 32'h0);
        advance();
        settle();
        chk("t4_m1_granted", 32'(grant), 32'h2);
        advance();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        // 5: ack lands exactly on the timeout cycle.
        set_m0(1'b1, 1'b1, 1'b1, 24'h000300, 16'h5A5A);
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        sAckI = 1'b1;
        settle();
        chk("t5_ack", 32'(m0AckO), 32'h1);
        chk("t5_err", 32'(m0ErrO), 32'h0);
        advance();
        sAckI = 1'b0;
        settle();
        chk("t5_grant_kept", 32'(grant), 32'h1);
        advance();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();

        // 6: reset asserted while m1 owns the bus mid-strobe.
        set_m1(1'b1, 1'b1, 1'b0, 24'h000400, 16'h0);
        tick();
        settle();
        chk("t6_pre_grant", 32'(grant), 32'h2);
        advance();
        rst   = 1'b0;
        sAckI = 1'b1;
        settle();
        chk("t6_grant", 32'(grant),  32'h0);
        chk("t6_scyc",  32'(sCycO),  32'h0);
        chk("t6_sstb",  32'(sStbO),  32'h0);
        chk("t6_ack",   32'(m1AckO), 32'h0);
        advance();
        sAckI = 1'b0;
        m0CycI = 1'b1;
        m1StbI = 1'b0;
        rst = 1'b1;
        tick();
        settle();
        chk("t6_tie_m0", 32'(grant), 32'h1);
        advance();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) m0CycI = ~m0CycI;
            if ($urandom_range(0, 5) == 0) m1CycI = ~m1CycI;
            m0StbI = ($urandom_range(0, 3) != 0);
            m1StbI = ($urandom_range(0, 3) != 0);
            m0WeI  = 1'($urandom_range(0, 1));
            m1WeI  = 1'($urandom_range(0, 1));
            m0AdrI = 24'($urandom);
            m1AdrI = 24'($urandom);
            m0DatI = 16'($urandom);
            m1DatI = 16'($urandom);
            sDatI  = 16'($urandom);
            sAckI  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 149) == 0) rst = 1'b0;
            else                             rst = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
